// File: rtl/ui_ingress_fifo.sv
// ui_ingress_fifo: strobe-edge byte capture into a small FIFO with a valid/ready
// output side and occupancy/overflow status.
// Ports: clk, rst_n (async, active-low), ena (design select, low freezes)
//        in_data/in_strobe   host side; a strobe rising edge pushes in_data
//        out_data/out_valid/out_ready  core side handshake
//        level/full/empty/overflow status; ovf_clear clears the sticky overflow
// Build option: define UI_INGRESS_SYNC_EN to add a 2-flop strobe/data synchroniser.
module ui_ingress_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_strobe,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   ovf_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic             strobe_s;
    logic [WIDTH-1:0] data_s;

`ifdef UI_INGRESS_SYNC_EN
    logic             strb_s1;
    logic             strb_s2;
    logic [WIDTH-1:0] data_s1;
    logic [WIDTH-1:0] data_s2;

    // Data rides a matching pipeline so the byte lines up with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_s1 <= 1'b0;
            strb_s2 <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            strb_s1 <= in_strobe;
            strb_s2 <= strb_s1;
            data_s1 <= in_data;
            data_s2 <= data_s1;
        end
    end

    assign strobe_s = strb_s2;
    assign data_s   = data_s2;
`else
    assign strobe_s = in_strobe;
    assign data_s   = in_data;
`endif

    logic             strb_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_req;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign out_valid = ~empty & ena;
    assign out_data  = mem[rd_ptr];

    assign push_req = strobe_s & ~strb_q & ena;
    assign pop      = out_valid & out_ready;
    // At full a concurrent pop frees the slot being written.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Edge detector keeps sampling while ena is low so a strobe that
    // rose during the freeze is not seen again when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= 1'b0;
        end else begin
            strb_q <= strobe_s;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Set has priority over clear; clear is frozen with ena low.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear && ena) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ui_ingress_fifo.sv
// tb_ui_ingress_fifo: self-checking bench for ui_ingress_fifo.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_ui_ingress_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
`ifdef UI_INGRESS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_strobe = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovf_clear = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [2:0]       level;
    logic             full;
    logic             empty;
    logic             overflow;

    ui_ingress_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: FIFO contents, sticky flag, and strobe edges still in flight.
    logic [7:0] q[$];
    bit         ovf = 1'b0;
    int         pend_due[$];
    logic [7:0] pend_dat[$];
    int         cyc = 0;

    // Drive one cycle of inputs at a negedge, advance the model across the
    // following posedge, and return at the next negedge.
    task automatic tick(input bit s, input logic [7:0] d, input bit rdy,
                        input bit en, input bit clr);
        bit         pop;
        bit         preq;
        bit         was_full;
        logic [7:0] pd;
        if (s && !in_strobe) begin
            pend_due.push_back(cyc + LAT - 1);
            pend_dat.push_back(d);
        end
        in_strobe = s;
        in_data   = d;
        out_ready = rdy;
        ena       = en;
        ovf_clear = clr;
        pop  = (q.size() > 0) && rdy && en;
        preq = 1'b0;
        pd   = 8'h00;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            preq = en;
            pd   = pend_dat[0];
            pend_due.delete(0);
            pend_dat.delete(0);
        end
        was_full = (q.size() == DEPTH);
        if (preq && was_full && !pop) ovf = 1'b1;
        else if (clr && en) ovf = 1'b0;
        if (pop) q.delete(0);
        if (preq && (!was_full || pop)) q.push_back(pd);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) tick(1'b0, 8'h00, rdy, 1'b1, 1'b0);
    endtask

    // One strobe pulse followed by two low cycles; the byte has landed on return.
    task automatic pulse(input logic [7:0] d, input bit rdy);
        tick(1'b1, d, rdy, 1'b1, 1'b0);
        tick(1'b0, d, rdy, 1'b1, 1'b0);
        tick(1'b0, d, rdy, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    task automatic test_single_write();
        tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early step %0d got %b exp 0", i, out_valid); end
            tick(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
        n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", out_data); end
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", level); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", empty); end
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain got %b exp 1", empty); end
        idle(1, 1'b0);
    endtask

    task automatic test_fill_overflow();
        for (int k = 1; k <= 4; k++) pulse(8'(k), 1'b0);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d exp 4", level); end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got %b exp 0", overflow); end
        pulse(8'h05, 1'b0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b exp 1", overflow); end
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level5 got %0d exp 4", level); end
        for (int k = 1; k <= 4; k++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin n_fail++; $display("FAIL fill_drain %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, 8'(k)); end
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty got %b exp 1", empty); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_sticky got %b exp 1", overflow); end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_clear got %b exp 0", overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_d [4];
        exp_d = '{8'h32, 8'h33, 8'h34, 8'h66};
        for (int k = 0; k < 4; k++) pulse(8'h31 + 8'(k), 1'b0);
        for (int i = 0; i < LAT; i++) tick(i == 0, 8'h66, i == LAT - 1, 1'b1, 1'b0);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL pp_level got %0d exp 4", level); end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full got %b exp 1", full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got %b exp 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin n_fail++; $display("FAIL pp_drain %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d[k]); end
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty got %b exp 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int k = 0; k < 10; k++) begin
            d = 8'h10 + 8'(k);
            pulse(d, 1'b0);
            n_tests++; if (out_valid !== 1'b1 || out_data !== d || level !== 3'd1) begin n_fail++; $display("FAIL wrap %0d got v=%b d=%h l=%0d exp v=1 d=%h l=1", k, out_valid, out_data, level, d); end
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty %0d got %b exp 1", k, empty); end
        end
    endtask

    task automatic test_ena_low();
        pulse(8'h71, 1'b0);
        pulse(8'h72, 1'b0);
        tick(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 2; i++) begin
            n_tests++; if (out_valid !== 1'b0 || level !== 3'd2) begin n_fail++; $display("FAIL ena_frozen %0d got v=%b l=%0d exp v=0 l=2", i, out_valid, level); end
            tick(1'b0, 8'h7F, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h71 || level !== 3'd2) begin n_fail++; $display("FAIL ena_restore got v=%b d=%h l=%0d exp v=1 d=71 l=2", out_valid, out_data, level); end
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_tests++; if (out_data !== 8'h72 || level !== 3'd1) begin n_fail++; $display("FAIL ena_second got d=%h l=%0d exp d=72 l=1", out_data, level); end
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ena_empty got %b exp 1", empty); end
    endtask

    task automatic test_random();
        int lowcnt;
        bit s;
        bit rdy;
        bit en;
        bit clr;
        bit ev;
        lowcnt = 2;
        for (int i = 0; i < 400; i++) begin
            s = 1'b0;
            if (in_strobe) s = 1'($urandom_range(0, 1));
            else if (lowcnt >= 2) s = ($urandom_range(0, 2) == 0);
            lowcnt = s ? 0 : lowcnt + 1;
            rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick(s, 8'($urandom), rdy, en, clr);
            ev = (q.size() > 0) && en;
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", i, out_valid, ev); end
            n_tests++; if (level !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_level c%0d got %0d exp %0d", i, level, q.size()); end
            n_tests++; if (full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c%0d got %b", i, full); end
            n_tests++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c%0d got %b", i, empty); end
            n_tests++; if (overflow !== ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d got %b exp %b", i, overflow, ovf); end
            if (ev) begin
                n_tests++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rnd_data c%0d got %h exp %h", i, out_data, q[0]); end
            end
        end
        idle(DEPTH + LAT + 3, 1'b1);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rnd_drain got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) pulse(8'h81 + 8'(k), 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_tests++; if (level !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL mid_setup got l=%0d o=%b exp l=3 o=1", level, overflow); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d exp 0", level); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL mid_flags got e=%b f=%b exp e=1 f=0", empty, full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b exp 0", overflow); end
        q.delete();
        pend_due.delete();
        pend_dat.delete();
        ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_tests++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after got e=%b v=%b exp e=1 v=0", empty, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_push_pop_full();
        test_wrap();
        test_ena_low();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ui_ingress_fifo.md
# ui_ingress_fifo

Input stage of the user project, directly behind the dedicated input pins. Captures a byte from `ui_in[7:0]` on each rising edge of a host-driven strobe pin, buffers it in a small FIFO, and presents it to the core through a valid/ready handshake. It also reports occupancy and overflow so the core can mirror status on `uo_out`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `WIDTH`, 8: data width in bits.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design-select; low freezes the block.
- `in_data`  in  WIDTH  byte from the input pins.
- `in_strobe`  in  1  host write strobe; a rising edge pushes one byte.
- `out_data`  out  WIDTH  FIFO head entry.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  core accepts the head entry.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overflow`  out  1  sticky flag: a push was dropped.
- `ovf_clear`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect: `strb_q` holds the previous strobe sample. `push_req = strobe_s & ~strb_q & ena`, where `strobe_s` is the strobe as seen after optional synchronisation (see Configuration).
- `pop = out_valid & out_ready` (`out_valid` already includes `ena`).
- Push is accepted when `push_req & (~full | pop)`. When full, a simultaneous pop and push are both performed and level stays DEPTH.
- Dropped push: `push_req & full & ~pop` sets `overflow`. Memory and pointers are unchanged.
- `ovf_clear` clears `overflow`. If a set and a clear occur in the same cycle, set wins.
- Storage is DEPTH×WIDTH flops. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked explicitly: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_data` equals `mem[rd_ptr]`. It is defined only while `out_valid` is high and must hold stable while `out_valid & ~out_ready`.
- `out_valid = ~empty & ena`.
- While `ena` is low, no push and no pop occur. Contents, pointers, `level` and `overflow` are retained. `strb_q` keeps sampling so that an edge spanning an `ena` rise is not double-counted.

## Timing
- Reset values: pointers 0, `level` 0, `empty` 1, `full` 0, `out_valid` 0, `overflow` 0, `strb_q` 0, synchroniser flops 0. `out_data` is don't-care but driven from memory; memory is not reset.
- Without sync, strobe rises in cycle N: the push is registered at the end of cycle N, and `out_valid` is 1 in cycle N+1 if the FIFO was empty. This is 1-cycle latency. There is no empty bypass.
- With sync: latency is 3 cycles from the strobe-sample edge to `out_valid`.
- A strobe held high pushes exactly once. The host must hold the strobe low for at least 1 sampled cycle between bytes (2 cycles when sync is enabled).
- A pop in cycle N advances the head in cycle N+1. Back-to-back pops at 1 per cycle are supported.
- `full`, `empty` and `level` update in the cycle after the causing push or pop.
- Reset asserted mid-operation clears everything immediately, with no clock needed. Any edge in flight is lost.

## Configuration
- `UI_INGRESS_SYNC_EN` defined:
  - `in_strobe` passes through a 2-flop synchroniser before edge detection.
  - `in_data` passes through a matching 2-stage register so the captured byte is aligned with its strobe.
  - Adds 2 cycles of latency.
- Not defined:
  - `in_strobe` and `in_data` are used directly, with only `strb_q` for edge detection.
  - The host must meet setup/hold relative to `clk`.

## Test plan
- Reset then single write: strobe an edge with `in_data`=0xA5 and `out_ready`=0. `out_valid`=1 and `out_data`=0xA5 after 1 cycle (3 with sync). `level`=1 and `empty`=0.
- Fill and overflow: 5 edges with 0x01..0x05 while `out_ready`=0 and DEPTH=4. `full`=1 and `level`=4. `overflow` sets on the 5th edge. Draining yields 0x01..0x04; 0x05 is lost.
- Simultaneous push/pop at full: with 4 entries and `out_ready`=1, give an edge with 0x66. `level` stays 4 and the head advances. The last entry out is 0x66 and `overflow` stays 0.
- Wrap-around: push and pop 10 bytes 0x10..0x19 one at a time. The output order matches and the pointers wrap twice.
- `ena` low: with 2 entries, drop `ena`, give a strobe edge and hold `out_ready`=1. There is no push and no pop, and `out_valid`=0. Raising `ena` restores `out_valid`=1 with the original head.
- Reset mid-stream: at 3 entries with `overflow`=1, pulse `rst_n` low asynchronously. All outputs return to reset values immediately, and `ovf_clear` is not needed.
